la_rrarb: RTL

LA_RRARB -- requirements
Module: la_rrarb

---
 rtl/la_rrarb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/la_rrarb.sv
// la_rrarb: round-robin arbiter with tenure lock.
// A grantee keeps the resource for as long as it holds its request; when it
// drops, the grant moves straight to the next requester in round-robin order.
// Optional feature: define LA_RRARB_TIMEOUT_EN to bound each tenure to
// TIMEOUT cycles whenever another requester is waiting.
module la_rrarb #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16,
    parameter     PROP    = "DEFAULT"
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 busy,
    output logic [$clog2(N)-1:0] gid
);

    localparam int GW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            busy_q, busy_d;
    logic [GW-1:0]   gid_q, gid_d;

`ifdef LA_RRARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]      cnt_q, cnt_d;
`endif

    logic [N-1:0]    cand;
    logic [GW:0]     pick_res;
    logic            found;
    logic [GW-1:0]   win;
    logic [GW-1:0]   win_next;
    logic            rearb;
    logic            drop;

    // First set bit of cand, searching start, start+1, ..., N-1, 0, ..., start-1.
    // Result is {found, index}.
    function automatic logic [GW:0] pick(input logic [N-1:0] c, input logic [GW-1:0] start);
        logic          f;
        logic [GW-1:0] w;
        int unsigned   idx;
        f = 1'b0;
        w = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = k + start;
            if (idx >= N) idx = idx - N;
            if (!f && c[idx]) begin
                f = 1'b1;
                w = idx[GW-1:0];
            end
        end
        return {f, w};
    endfunction

    // Candidate search, tenure decision and next-state computation.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        gid_d    = gid_q;
`ifdef LA_RRARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        rearb    = 1'b0;
        drop     = 1'b0;

        // The current owner never competes in a re-arbitration.
        cand = req;
        if (state_q == OWNED) cand[gid_q] = 1'b0;

        pick_res = pick(cand, ptr_q);
        found    = pick_res[GW];
        win      = pick_res[GW-1:0];
        win_next = (int'(win) == N - 1) ? '0 : win + 1'b1;

        case (state_q)
            IDLE: begin
                if (en && found) rearb = 1'b1;
            end
            OWNED: begin
                if (req[gid_q]) begin
`ifdef LA_RRARB_TIMEOUT_EN
                    if (cnt_q == TO_LAST && en && found) rearb = 1'b1;
                    else if (cnt_q != TO_LAST) cnt_d = cnt_q + 8'd1;
`endif
                end else if (en && found) begin
                    rearb = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            default: drop = 1'b1;
        endcase

        if (rearb) begin
            state_d      = OWNED;
            grant_d      = '0;
            grant_d[win] = 1'b1;
            busy_d       = 1'b1;
            gid_d        = win;
            ptr_d        = win_next;
`ifdef LA_RRARB_TIMEOUT_EN
            cnt_d        = '0;
`endif
        end else if (drop) begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            gid_d   = '0;
`ifdef LA_RRARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
`ifdef LA_RRARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
`ifdef LA_RRARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign gid   = gid_q;

endmodule
